// File: rtl/ss_digit_mux.sv
// ss_digit_mux: eight-digit seven-segment scanner with blanking gaps and per-frame snapshot; define SS_LEAD_ZERO_BLANK_EN for leading-zero suppression
module ss_digit_mux #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] digits,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_in,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);
  localparam int CMAX = SCAN_DIV > BLANK_CYC ? SCAN_DIV : BLANK_CYC;
  localparam int CW = $clog2(CMAX);
  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;
  state_t state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [2:0] idx, nidx;
  logic load, lit, sup;
  logic [31:0] snap_d, src_d;
  logic [7:0] snap_en, src_en, snap_dp, src_dp, nan;
  logic [6:0] nseg;
  logic ndp;
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0: decode = 7'h40;
      4'd1: decode = 7'h79;
      4'd2: decode = 7'h24;
      4'd3: decode = 7'h30;
      4'd4: decode = 7'h19;
      4'd5: decode = 7'h12;
      4'd6: decode = 7'h02;
      4'd7: decode = 7'h78;
      4'd8: decode = 7'h00;
      4'd9: decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction
  // state, phase counter and slot index; reset parks in BLANK of slot 7 so slot 0 comes first
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= BLANK;
      cnt <= '0;
      idx <= 3'd7;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      idx <= nidx;
    end
  // phase sequencing; load marks the BLANK->SHOW edge that starts a new frame
  always_comb begin
    nstate = state;
    ncnt = cnt + 1'b1;
    nidx = idx;
    load = 1'b0;
    if (state == SHOW && cnt == CW'(SCAN_DIV - 1)) begin
      nstate = BLANK;
      ncnt = '0;
    end else if (state == BLANK && cnt == CW'(BLANK_CYC - 1)) begin
      nstate = SHOW;
      ncnt = '0;
      nidx = idx + 3'd1;
      load = (idx == 3'd7);
    end
  end
  // frame snapshot so mid-frame input changes never tear the display
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      snap_d <= '0;
      snap_en <= '0;
      snap_dp <= '0;
    end else if (load) begin
      snap_d <= digits;
      snap_en <= digit_en;
      snap_dp <= dp_in;
    end
  assign src_d  = load ? digits : snap_d;
  assign src_en = load ? digit_en : snap_en;
  assign src_dp = load ? dp_in : snap_dp;
`ifdef SS_LEAD_ZERO_BLANK_EN
  logic [7:0] nz;
  for (genvar g = 0; g < 8; g++) begin : g_nz
    assign nz[g] = |src_d[4*g +: 4];
  end
  assign sup = (nidx != 3'd0) && ((nz >> nidx) == 8'd0);
`else
  assign sup = 1'b0;
`endif
  // next display drive, computed from the state and snapshot being loaded this edge
  always_comb begin
    lit = (nstate == SHOW) && src_en[nidx] && !sup;
    nan = lit ? ~(8'd1 << nidx) : 8'hFF;
    nseg = lit ? decode(src_d[{nidx, 2'b00} +: 4]) : 7'h7F;
    ndp = lit ? ~src_dp[nidx] : 1'b1;
  end
  // registered outputs; async reset blanks the display at once
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      an <= 8'hFF;
      seg <= 7'h7F;
      dp <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an <= nan;
      seg <= nseg;
      dp <= ndp;
      frame_tick <= load;
    end
endmodule

// File: doc/ss_digit_mux.md
SS_DIGIT_MUX -- requirements
Module: ss_digit_mux

Interface
REQ-001 Parameter SCAN_DIV, default 100000: SHOW-phase length in clk cycles per digit slot; legal values are 2 and above.
REQ-002 Parameter BLANK_CYC, default 1000: BLANK-phase (anti-ghosting) length in clk cycles per digit slot; legal values are 1 and above.
REQ-003 clk  input  1  system clock; reset  input  1  asynchronous, active-high reset.
REQ-004 digits  input  32  eight BCD nibbles; digits[4i+3:4i] is digit i, where digit 0 is rightmost and digit 7 is leftmost.
REQ-005 digit_en  input  8  per-digit enable, active-high.
REQ-006 dp_in  input  8  per-digit decimal point, active-high.
REQ-007 an  output  8  anode selects, active-low, one-hot-low or all-high.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 dp  output  1  decimal point, active-low.
REQ-010 frame_tick  output  1  one-cycle pulse on each snapshot edge.

Function
REQ-011 The block SHALL implement a two-state FSM (SHOW, BLANK), a phase counter cnt and a 3-bit slot index idx.
REQ-012 In SHOW, the FSM SHALL stay for SCAN_DIV cycles (cnt 0..SCAN_DIV-1), then move to BLANK with cnt=0.
REQ-013 In BLANK, the FSM SHALL stay for BLANK_CYC cycles, then move to SHOW with cnt=0 and idx=idx+1 mod 8; idx wraps 7->0.
REQ-014 On every BLANK->SHOW edge with new idx=0, the block SHALL latch digits, digit_en and dp_in into a snapshot and pulse frame_tick for that cycle only.
REQ-015 All displayed values SHALL come from the snapshot, so mid-frame input changes are invisible until the next frame.
REQ-016 an, seg, dp and frame_tick SHALL be registers loaded on the same edge as the state/idx update; slot idx 0 SHALL display the snapshot taken on that edge.
REQ-017 In BLANK: an=8'hFF, seg=7'h7F, dp=1.
REQ-018 In SHOW with snapshot digit_en[idx]=1 and the digit not suppressed: an[idx]=0, all other an bits=1, seg=decode(digit idx), dp=~dp_in[idx].
REQ-019 In SHOW with snapshot digit_en[idx]=0, or with the digit suppressed: an=8'hFF, seg=7'h7F, dp=1.
REQ-020 Decode (active-low, {g..a}): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10; codes 10-15 SHALL give 7'h7F (blank).
REQ-021 Slot period SHALL be SCAN_DIV+BLANK_CYC cycles; frame period SHALL be 8*(SCAN_DIV+BLANK_CYC) cycles.

Reset
REQ-022 On reset: state=BLANK, cnt=0, idx=7, an=8'hFF, seg=7'h7F, dp=1, frame_tick=0, snapshot=0.
REQ-023 Reset asserted mid-SHOW SHALL blank the display immediately (asynchronously).
REQ-024 After reset release, the first SHOW SHALL be slot 0, entered after BLANK_CYC cycles with a fresh snapshot.

Configuration
REQ-025 Macro SS_LEAD_ZERO_BLANK_EN: when defined, slot i (i>=1) SHALL be suppressed if snapshot digits i..7 all equal 0; slot 0 SHALL never be suppressed. This suppression SHALL ignore digit_en.
REQ-026 When SS_LEAD_ZERO_BLANK_EN is undefined, no zero suppression SHALL occur, and zeros SHALL display as 7'h40.

Verification
All scenarios use SCAN_DIV=4 and BLANK_CYC=2, giving a 6-cycle slot and a 48-cycle frame.
REQ-027 Release reset; digits=32'h0000_1234, digit_en=8'hFF -> an=8'hFF for 2 cycles, then an=8'hFE with seg=7'h19 for 4 cycles; frame_tick pulses once on that edge.
REQ-028 Same stimulus, one full frame -> an walks FE,FD,FB,F7,EF,DF,BF,7F with BLANK gaps between slots; slots 1-3 show 7'h30, 7'h24, 7'h79.
REQ-029 With SS_LEAD_ZERO_BLANK_EN defined and digits=32'h0000_0000 -> only slot 0 lights (seg=7'h40); slots 1-7 show an=8'hFF. Without the macro, all 8 slots show 7'h40.
REQ-030 Change digits from 32'h1 to 32'h2 during slot 3 -> slot 0 of the next frame shows 7'h24, and slots 4-7 of the current frame are unaffected.
REQ-031 digit_en=8'h0F and dp_in=8'h01 -> slots 4-7 show an=8'hFF; slot 0 shows dp=0; slots 1-3 show dp=1.
REQ-032 Assert reset during SHOW of slot 5 -> on the same cycle an=8'hFF and seg=7'h7F; after release, slot 0 is next.
